pc_fetch_ctrl: RTL and testbench

//  Program-counter register plus instruction-fetch sequencer for the OTTER core.
//  It consumes the jal/branch/jalr targets from the branch address generator,

---
 rtl/otter_pkg.sv | 31 +++
 rtl/pc_target_mux.sv | 49 ++++
 rtl/pc_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared types and constants for the OTTER fetch path
//
// Purpose: next-PC select encoding, fetch FSM states and the NOP word
//          loaded into the instruction register at reset.
// Ports:   none (package).

package otter_pkg;

  // Encoding of the pc_sel input. Codes 6 and 7 are left unnamed and
  // behave like PC_SEQ.
  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pc_sel_t;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK = ~32'h0000_0003;

endpackage

// File: rtl/pc_target_mux.sv
// rtl/pc_target_mux.sv - redirect target select, alignment and misalign detect
//
// Purpose: decodes pc_sel into a redirect target, clears jalr bit 0,
//          word-aligns the result and flags a misaligned raw target.
// Ports:
//   pc_sel    in  3   next-PC source select
//   jal       in  32  jal target
//   branch    in  32  branch target
//   jalr      in  32  jalr target (bit 0 ignored)
//   mtvec     in  32  trap vector
//   mepc      in  32  trap return address
//   take      out 1   pc_sel names a real redirect source
//   target    out 32  word-aligned redirect target
//   misalign  out 1   raw target had nonzero bits [1:0]

module pc_target_mux
  import otter_pkg::*;
(
  input  logic [2:0]  pc_sel,
  input  logic [31:0] jal,
  input  logic [31:0] branch,
  input  logic [31:0] jalr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        take,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] raw;

  always_comb begin
    take = 1'b1;
    raw  = 32'h0000_0000;
    case (pc_sel)
      PC_JALR:   raw = jalr & ~32'h0000_0001;
      PC_BRANCH: raw = branch;
      PC_JAL:    raw = jal;
      PC_MTVEC:  raw = mtvec;
      PC_MEPC:   raw = mepc;
      default:   take = 1'b0;
    endcase
  end

  assign target   = raw & ALIGN_MASK;
  // Only meaningful for a real redirect; a sequential select never flags.
  assign misalign = take & (raw[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and single-outstanding instruction fetch
//
// Purpose: holds the fetch PC, issues one instruction-memory read at a time,
//          and presents each returned word on ir/pc with a valid/ready
//          handshake. Redirects override the fetch PC from any state.
// Ports:
//   CLK          in   1   core clock
//   RST          in   1   asynchronous active-high reset
//   redirect     in   1   take the pc_sel target this cycle
//   pc_sel       in   3   redirect source select
//   jal/branch/jalr/mtvec/mepc  in 32  candidate targets
//   imem_req     out  1   one-cycle read request
//   imem_addr    out  32  read address (valid with imem_req)
//   imem_rvalid  in   1   read data valid
//   imem_rdata   in   32  read data
//   ir_valid     out  1   ir/pc hold a fetched instruction
//   ir_ready     in   1   downstream accepts ir
//   ir           out  32  instruction word
//   pc           out  32  address of ir
//   pc_plus4     out  32  pc + 4
//   misalign     out  1   one-cycle pulse for a misaligned redirect target

module pc_fetch_ctrl
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        redirect,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] jal,
  input  logic [31:0] branch,
  input  logic [31:0] jalr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic         drop;

  logic         sel_take;
  logic [31:0]  sel_target;
  logic         sel_misalign;
  logic         redir;
  logic [31:0]  next_addr;
  logic [31:0]  fetch_pc_inc;

  pc_target_mux u_target_mux (
    .pc_sel   (pc_sel),
    .jal      (jal),
    .branch   (branch),
    .jalr     (jalr),
    .mtvec    (mtvec),
    .mepc     (mepc),
    .take     (sel_take),
    .target   (sel_target),
    .misalign (sel_misalign)
  );

  // A sequential/reserved select makes redirect a no-op.
  assign redir        = redirect & sel_take;
  // Address of the request issued on entry to S_REQ: a same-cycle redirect
  // wins over the stored fetch PC.
  assign next_addr    = redir ? sel_target : fetch_pc;
  assign fetch_pc_inc = fetch_pc + 32'd4;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_BOOT;
      fetch_pc  <= RESET_VEC;
      drop      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_VEC;
      ir_valid  <= 1'b0;
      ir        <= NOP_INSTR;
      pc        <= RESET_VEC;
      pc_plus4  <= RESET_VEC + 32'd4;
      misalign  <= 1'b0;
    end else begin
      misalign <= redir & sel_misalign;
      imem_req <= 1'b0;
      if (redir) begin
        fetch_pc <= sel_target;
      end

      case (state)
        S_BOOT: begin
          // Any rvalid still arriving from before reset is ignored here.
          state     <= S_REQ;
          imem_req  <= 1'b1;
          imem_addr <= next_addr;
        end

        S_REQ: begin
          // The request on the bus this cycle goes out regardless; a
          // redirect only marks its response for discard.
          state <= S_WAIT;
          if (redir) begin
            drop <= 1'b1;
          end
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop || redir) begin
              drop      <= 1'b0;
              state     <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= next_addr;
            end else begin
              ir       <= imem_rdata;
              pc       <= fetch_pc;
              pc_plus4 <= fetch_pc_inc;
              ir_valid <= 1'b1;
              fetch_pc <= fetch_pc_inc;
              state    <= S_HOLD;
            end
          end else if (redir) begin
            drop <= 1'b1;
          end
        end

        S_HOLD: begin
          // A redirect flushes the held instruction; if ir_ready was also
          // high the downstream already consumed it this cycle.
          if (ir_ready || redir) begin
            ir_valid  <= 1'b0;
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= next_addr;
          end
        end

        default: begin
          state <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl

module tb_pc_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        redirect = 1'b0;
  logic [2:0]  pc_sel = 3'd0;
  logic [31:0] jal = 32'h0;
  logic [31:0] branch = 32'h0;
  logic [31:0] jalr = 32'h0;
  logic [31:0] mtvec = 32'h0;
  logic [31:0] mepc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int pend = 0;
  logic [31:0] pend_addr = 32'h0;
  int acc_count = 0;

  pc_fetch_ctrl #(.RESET_VEC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .redirect(redirect), .pc_sel(pc_sel),
    .jal(jal), .branch(branch), .jalr(jalr), .mtvec(mtvec), .mepc(mepc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .pc(pc),
    .pc_plus4(pc_plus4), .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Memory: response exactly mem_lat cycles after the request cycle.
  // Deliberately not reset so a pre-reset response can arrive late.
  always @(posedge CLK) begin
    if (imem_req) begin
      pend      <= mem_lat;
      pend_addr <= imem_addr;
    end else if (pend != 0) begin
      pend <= pend - 1;
    end
  end
  assign imem_rvalid = (pend == 1);
  assign imem_rdata  = imem_rvalid ? instr_of(pend_addr) : 32'h0;

  always @(posedge CLK) begin
    if (ir_valid && ir_ready) acc_count <= acc_count + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b exp 0", ir_valid); end
    checks++; if (ir !== 32'h0000_0013) begin errors++; $display("FAIL reset_ir got %h exp 00000013", ir); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", pc); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h exp 00000004", pc_plus4); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    RST = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL release_cycle_req got %b exp 0", imem_req); end
    tick();
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp;
      exp = 32'(k * 4);
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp) begin errors++; $display("FAIL seq_req%0d got %b/%h exp 1/%h", k, imem_req, imem_addr, exp); end
      tick();
      checks++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL seq_wait%0d got req %b valid %b exp 0/0", k, imem_req, ir_valid); end
      tick();
      checks++; if (ir_valid !== 1'b1 || pc !== exp || ir !== instr_of(exp) || pc_plus4 !== exp + 32'd4) begin
        errors++; $display("FAIL seq_hold%0d got v%b pc %h ir %h p4 %h exp v1 pc %h", k, ir_valid, pc, ir, pc_plus4, exp);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    ir_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (ir_valid !== 1'b1 || pc !== 32'hC || ir !== instr_of(32'hC) || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall%0d got v%b pc %h ir %h req %b exp v1 pc 0000000c req 0", i, ir_valid, pc, ir, imem_req);
      end
      tick();
    end
    ir_ready = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL stall_release got %b/%h exp 1/00000010", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 2;
    tick();
    redirect = 1'b1; pc_sel = 3'd2; branch = 32'h100;
    tick();
    redirect = 1'b0; pc_sel = 3'd0;
    checks++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rw_wait got req %b v %b exp 0/0", imem_req, ir_valid); end
    mem_lat = 1;
    tick();
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped got v %b exp 0", ir_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rw_addr got %b/%h exp 1/00000100", imem_req, imem_addr); end
    tick();
    tick();
    checks++; if (ir_valid !== 1'b1 || pc !== 32'h100 || ir !== instr_of(32'h100)) begin errors++; $display("FAIL rw_hold got v%b pc %h ir %h exp pc 00000100", ir_valid, pc, ir); end
    tick();
  endtask

  task automatic test_jalr_misalign();
    redirect = 1'b1; pc_sel = 3'd1; jalr = 32'h203;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL jm_req_issued got %b/%h exp 1/00000104", imem_req, imem_addr); end
    tick();
    redirect = 1'b0; pc_sel = 3'd0;
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL jm_pulse got %b exp 1", misalign); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL jm_pulse_end got %b exp 0", misalign); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || ir_valid !== 1'b0) begin errors++; $display("FAIL jm_addr got %b/%h v%b exp 1/00000200 v0", imem_req, imem_addr, ir_valid); end
    tick();
    tick();
    checks++; if (pc !== 32'h200 || ir_valid !== 1'b1) begin errors++; $display("FAIL jm_hold got pc %h v%b exp 00000200 v1", pc, ir_valid); end
    tick();
    redirect = 1'b1; pc_sel = 3'd1; jalr = 32'h201;
    tick();
    redirect = 1'b0; pc_sel = 3'd0;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL jm_bit0 got %b exp 0", misalign); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL jm_addr2 got %b/%h exp 1/00000200", imem_req, imem_addr); end
    tick();
    tick();
  endtask

  task automatic test_hold_redirect();
    int acc0;
    acc0 = acc_count;
    redirect = 1'b1; pc_sel = 3'd4; mtvec = 32'h80;
    tick();
    redirect = 1'b0; pc_sel = 3'd0;
    checks++; if (acc_count !== acc0 + 1) begin errors++; $display("FAIL hr_consumed got %0d exp %0d", acc_count, acc0 + 1); end
    checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin errors++; $display("FAIL hr_addr got v%b %b/%h exp v0 1/00000080", ir_valid, imem_req, imem_addr); end
    tick();
    checks++; if (acc_count !== acc0 + 1) begin errors++; $display("FAIL hr_once got %0d exp %0d", acc_count, acc0 + 1); end
    tick();
    checks++; if (pc !== 32'h80 || ir !== instr_of(32'h80) || pc_plus4 !== 32'h84) begin errors++; $display("FAIL hr_hold got pc %h ir %h p4 %h exp 00000080", pc, ir, pc_plus4); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; pc_sel = 3'd3; jal = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; pc_sel = 3'd0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
    tick();
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h/%h exp fffffffc/00000000", pc, pc_plus4); end
    redirect = 1'b1; pc_sel = 3'd7;
    tick();
    redirect = 1'b0; pc_sel = 3'd0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || misalign !== 1'b0) begin errors++; $display("FAIL wrap_noop got %b/%h m%b exp 1/00000000 m0", imem_req, imem_addr, misalign); end
    tick();
    tick();
    tick();
  endtask

  task automatic test_rst_mid_fetch();
    bit seen;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL rst_pre got %b/%h exp 1/00000004", imem_req, imem_addr); end
    mem_lat = 3;
    tick();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h13 || pc !== 32'h0 || pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL rst_async got req %b v %b ir %h pc %h p4 %h", imem_req, ir_valid, ir, pc, pc_plus4);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rst_refetch got %b/%h v%b exp 1/00000000 v0", imem_req, imem_addr, ir_valid); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = ir_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_timeout got ir_valid 0 exp 1 within 10 cycles"); end
    checks++; if (pc !== 32'h0 || ir !== instr_of(32'h0)) begin errors++; $display("FAIL rst_data got pc %h ir %h exp 00000000/%h", pc, ir, instr_of(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_jalr_misalign();
    test_hold_redirect();
    test_wrap();
    test_rst_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
